axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, meaning number of read clients (2..16); client i drives arid = i.
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning beats per cache-line burst (4 or 8); arlen = LINE_WORDS-1 for line reads.
REQ-003 SHALL have parameter RESET_RR, default 0, meaning client index holding round-robin priority after reset.
REQ-004 SHALL have port aclk  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_req  in  NUM_RD  per-client read request.
REQ-007 SHALL have port rd_type  in  3*NUM_RD  per-client type: 3'b000/001/010 single byte/half/word, 3'b100 line burst.
REQ-008 SHALL have port rd_addr  in  32*NUM_RD  per-client byte address.
REQ-009 SHALL have port rd_rdy  out  NUM_RD  per-client request accepted this cycle.
REQ-010 SHALL have port ret_valid  out  NUM_RD  one-hot return-beat strobe.
REQ-011 SHALL have port ret_last  out  1  final beat of the current return.
REQ-012 SHALL have port ret_data  out  32  return beat data, shared by all clients.
REQ-013 SHALL have ports arid out 4, araddr out 32, arlen out 8, arsize out 3, arvalid out 1, arready in 1: the AXI AR channel.
REQ-014 SHALL have ports rid in 4, rdata in 32, rlast in 1, rvalid in 1, rready out 1: the AXI R channel.

Function
REQ-015 SHALL drive arburst/arlock/arcache/arprot outside this block; arburst INCR is implied.
REQ-016 SHALL treat client i as eligible when rd_req[i]=1 and outstanding[i]=0.
REQ-017 SHALL grant round-robin: the first eligible index at or after rr_ptr, wrapping modulo NUM_RD.
REQ-018 SHALL assert rd_rdy[grantee] combinationally only when the AR holding register is empty or arready=1 this cycle; all other rd_rdy bits SHALL be 0.
REQ-019 SHALL, on rd_req[i]&rd_rdy[i], load the AR register and set rr_ptr=(i+1) mod NUM_RD.
  - arid=i; araddr=rd_addr[i].
  - Line type: arlen=LINE_WORDS-1, arsize=3'b010, araddr aligned down to a 4*LINE_WORDS-byte boundary.
  - Single type: arlen=0, arsize=type[1:0].
  - Sets outstanding[i].
REQ-020 SHALL assert arvalid the cycle after acceptance and hold arid/araddr/arlen/arsize stable until arvalid&arready.
REQ-021 SHALL support back-to-back acceptance: AR handshake and new acceptance in the same cycle, giving one request per cycle at arready=1.
REQ-022 SHALL tie rready=1 while aresetn=1.
REQ-023 SHALL, on rvalid with outstanding[rid]=1, register the beat: next cycle ret_valid=one-hot(rid), ret_data=rdata, ret_last=rlast; fixed 1-cycle latency.
REQ-024 SHALL clear outstanding[rid] on a beat with rlast=1; the same client SHALL be re-grantable in that same cycle.
REQ-025 SHALL accept interleaved beats from different rids and route each by rid alone.
REQ-026 SHALL drop beats with rid>=NUM_RD or outstanding[rid]=0: no ret_valid, no state change.
REQ-027 SHALL drive ret_valid=0 and leave ret_data/ret_last don't-care in cycles with no registered beat.

Reset
REQ-028 SHALL, while aresetn=0, asynchronously force:
  - arvalid=0, rready=0, rd_rdy=0, ret_valid=0, ret_last=0, ret_data=0;
  - arid/araddr/arlen/arsize=0, outstanding=0, rr_ptr=RESET_RR.
REQ-029 SHALL, on reset mid-burst, abandon all transactions; the bench SHALL reset the AXI slave together with this block.

Verification
REQ-030 Single client 0, line read 0x1C00_0014, arready=1 -> arvalid next cycle, araddr=0x1C00_0010, arlen=3, arsize=2, arid=0; 4 R beats -> ret_valid=01 for 4 cycles, ret_last on the 4th only.
REQ-031 Clients 0 and 1 both request each cycle, rr_ptr=0 -> grants 0,1 in that order; after both complete, next grant again 0 then 1.
REQ-032 arready held 0 for 5 cycles -> AR fields stable, rd_rdy=00 throughout, exactly one AR handshake.
REQ-033 Interleaved R beats rid 1,0,1,0 (two single reads) -> ret_valid 10,01,10,01 with matching data; ret_last=1 on each.
REQ-034 Stray beat rid=3 with NUM_RD=2, or rid=0 with nothing outstanding -> no ret_valid, outstanding unchanged.
REQ-035 aresetn low during beat 2 of 4 -> all outputs 0 within the same cycle; after release, a fresh single read from client 1 completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin arbiter merging per-client reads onto one AXI AR/R channel pair
module axi_rd_arbiter #(
    parameter int NUM_RD     = 2,
    parameter int LINE_WORDS = 4,
    parameter int RESET_RR   = 0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [3*NUM_RD-1:0]      rd_type,
    input  logic [32*NUM_RD-1:0]     rd_addr,
    output logic [NUM_RD-1:0]        rd_rdy,
    output logic [NUM_RD-1:0]        ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int          PW        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [31:0] LINE_MASK = ~(32'(4 * LINE_WORDS) - 32'd1);

    logic [NUM_RD-1:0] outstanding;
    logic [NUM_RD-1:0] rid_oh;
    logic [NUM_RD-1:0] beat_hit;
    logic [NUM_RD-1:0] clr_mask;
    logic [NUM_RD-1:0] eligible;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_idx;
    logic              grant_found;
    logic              accept;
    logic [2:0]        sel_type;
    logic [31:0]       sel_addr;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_RD) s = s - NUM_RD;
        return PW'(s);
    endfunction

    // A final beat frees its client in the same cycle, so it can be re-granted immediately.
    always_comb begin
        rid_oh   = (int'(rid) < NUM_RD) ? (NUM_RD'(1) << rid) : '0;
        beat_hit = rvalid ? (rid_oh & outstanding) : '0;
        clr_mask = rlast ? beat_hit : '0;
        eligible = rd_req & ~(outstanding & ~clr_mask);
    end

    // Lowest offset from rr_ptr wins; the loop runs downward so the last hit is the winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_RD - 1; k >= 0; k--) begin
            if (eligible[wrap_add(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_ptr, k);
            end
        end
        accept   = aresetn && grant_found && (!arvalid || arready);
        rd_rdy   = accept ? (NUM_RD'(1) << grant_idx) : '0;
        sel_type = rd_type[int'(grant_idx) * 3 +: 3];
        sel_addr = rd_addr[int'(grant_idx) * 32 +: 32];
    end

    assign rready = aresetn;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
        end else if (accept) begin
            arvalid <= 1'b1;
            arid    <= 4'(grant_idx);
            if (sel_type[2]) begin
                araddr <= sel_addr & LINE_MASK;
                arlen  <= 8'(LINE_WORDS - 1);
                arsize <= 3'b010;
            end else begin
                araddr <= sel_addr;
                arlen  <= 8'd0;
                arsize <= {1'b0, sel_type[1:0]};
            end
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
            rr_ptr      <= PW'(RESET_RR);
        end else begin
            outstanding <= (outstanding & ~clr_mask) | rd_rdy;
            if (accept) rr_ptr <= wrap_add(grant_idx, 1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ret_valid <= '0;
            ret_last  <= 1'b0;
            ret_data  <= '0;
        end else begin
            ret_valid <= beat_hit;
            ret_last  <= (|beat_hit) & rlast;
            if (|beat_hit) ret_data <= rdata;
        end
    end

endmodule
